// File: rtl/mem_req_sched.sv
// mem_req_sched: round-robin icache/dcache miss scheduler in front of a
// single-ported, fixed-latency main memory (one transaction in flight).
//
// Ports:
//   clk, rst_aL            clock, async active-low reset
//   icache_req_* / resp_*  icache read request (valid/ready) and response
//   dcache_req_* / resp_*  dcache read/write request (valid/ready), response
//   mem_req_*              one-cycle issue pulse and fields to main_mem
//   mem_resp_*             main_mem response with echoed cache-type tag
//   err                    sticky: response tag mismatch or timeout
// Optional (macro MEM_SCHED_PERF_CNT_EN): perf_icache_grants,
//   perf_dcache_grants, perf_conflict_cycles saturating 32-bit counters.
module mem_req_sched #(
  parameter int BLOCK_ADDR_W = 26,
  parameter int BLOCK_DATA_W = 512,
  parameter int MEM_LATENCY  = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst_aL,
  input  logic                    icache_req_valid,
  input  logic [BLOCK_ADDR_W-1:0] icache_req_block_addr,
  output logic                    icache_req_ready,
  output logic                    icache_resp_valid,
  output logic [BLOCK_DATA_W-1:0] icache_resp_block_data,
  input  logic                    dcache_req_valid,
  input  logic                    dcache_req_type,
  input  logic [BLOCK_ADDR_W-1:0] dcache_req_block_addr,
  input  logic [BLOCK_DATA_W-1:0] dcache_req_block_data,
  output logic                    dcache_req_ready,
  output logic                    dcache_resp_valid,
  output logic [BLOCK_DATA_W-1:0] dcache_resp_block_data,
  output logic                    mem_req_valid,
  output logic                    mem_req_cache_type,
  output logic                    mem_req_type,
  output logic [BLOCK_ADDR_W-1:0] mem_req_block_addr,
  output logic [BLOCK_DATA_W-1:0] mem_req_block_data,
  input  logic                    mem_resp_valid,
  input  logic                    mem_resp_cache_type,
  input  logic [BLOCK_DATA_W-1:0] mem_resp_block_data,
  output logic                    err
`ifdef MEM_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]             perf_icache_grants,
  output logic [31:0]             perf_dcache_grants,
  output logic [31:0]             perf_conflict_cycles
`endif
);

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
  localparam int   CNT_W = $clog2(TIMEOUT + 1);

  if (TIMEOUT <= MEM_LATENCY) begin : g_cfg_chk
    $error("TIMEOUT must exceed MEM_LATENCY");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t                  state;
  logic                    grant;
  logic                    rr_last;
  logic [CNT_W-1:0]        wait_cnt;

  logic                    i_vld;
  logic [BLOCK_ADDR_W-1:0] i_addr;
  logic                    d_vld;
  logic                    d_type;
  logic [BLOCK_ADDR_W-1:0] d_addr;
  logic [BLOCK_DATA_W-1:0] d_data;

  logic i_acc;
  logic d_acc;
  logic timeout;
  logic done;
  logic pick;

  assign icache_req_ready = ~i_vld;
  assign dcache_req_ready = ~d_vld;

  assign i_acc = icache_req_valid & ~i_vld;
  assign d_acc = dcache_req_valid & ~d_vld;

  assign timeout = (state == WAIT) & ~mem_resp_valid
                 & (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Granted buffer is released after its response or on timeout.
  assign done = (state == RESP) | timeout;

  // On a tie the requester that did not win last time is picked.
  always_comb begin
    pick = REQ_D;
    unique case (1'b1)
      i_vld & d_vld:  pick = ~rr_last;
      i_vld & ~d_vld: pick = REQ_I;
      default:        pick = REQ_D;
    endcase
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      i_vld  <= 1'b0;
      i_addr <= '0;
      d_vld  <= 1'b0;
      d_type <= 1'b0;
      d_addr <= '0;
      d_data <= '0;
    end else begin
      if (i_acc) begin
        i_vld  <= 1'b1;
        i_addr <= icache_req_block_addr;
      end else if (done && grant == REQ_I) begin
        i_vld  <= 1'b0;
      end
      if (d_acc) begin
        d_vld  <= 1'b1;
        d_type <= dcache_req_type;
        d_addr <= dcache_req_block_addr;
        d_data <= dcache_req_block_data;
      end else if (done && grant == REQ_D) begin
        d_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state                  <= IDLE;
      grant                  <= REQ_I;
      rr_last                <= REQ_D;
      wait_cnt               <= '0;
      mem_req_valid          <= 1'b0;
      mem_req_cache_type     <= 1'b0;
      mem_req_type           <= 1'b0;
      mem_req_block_addr     <= '0;
      mem_req_block_data     <= '0;
      icache_resp_valid      <= 1'b0;
      icache_resp_block_data <= '0;
      dcache_resp_valid      <= 1'b0;
      dcache_resp_block_data <= '0;
      err                    <= 1'b0;
    end else begin
      mem_req_valid     <= 1'b0;
      icache_resp_valid <= 1'b0;
      dcache_resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_vld | d_vld) begin
            grant              <= pick;
            rr_last            <= pick;
            mem_req_valid      <= 1'b1;
            mem_req_cache_type <= pick;
            mem_req_type       <= pick & d_type;
            mem_req_block_addr <= pick ? d_addr : i_addr;
            mem_req_block_data <= pick ? d_data : '0;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) begin
            // Mismatched tag is flagged but routing follows the grant.
            if (mem_resp_cache_type != grant) err <= 1'b1;
            if (grant == REQ_D) begin
              dcache_resp_valid      <= 1'b1;
              dcache_resp_block_data <= d_type ? '0 : mem_resp_block_data;
            end else begin
              icache_resp_valid      <= 1'b1;
              icache_resp_block_data <= mem_resp_block_data;
            end
            state <= RESP;
          end else if (timeout) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      perf_icache_grants   <= '0;
      perf_dcache_grants   <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      if (state == ISSUE && grant == REQ_I && !(&perf_icache_grants))
        perf_icache_grants <= perf_icache_grants + 32'd1;
      if (state == ISSUE && grant == REQ_D && !(&perf_dcache_grants))
        perf_dcache_grants <= perf_dcache_grants + 32'd1;
      if (i_vld && d_vld && !(&perf_conflict_cycles))
        perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_sched.sv
// tb_mem_req_sched: directed + randomized checks of mem_req_sched
// against a main_mem model and a request/response scoreboard.
module tb_mem_req_sched;

  localparam int AW  = 26;
  localparam int DW  = 512;
  localparam int LAT = 4;
  localparam int TO  = 8;

  logic          clk;
  logic          rst_aL;
  logic          icache_req_valid;
  logic [AW-1:0] icache_req_block_addr;
  logic          icache_req_ready;
  logic          icache_resp_valid;
  logic [DW-1:0] icache_resp_block_data;
  logic          dcache_req_valid;
  logic          dcache_req_type;
  logic [AW-1:0] dcache_req_block_addr;
  logic [DW-1:0] dcache_req_block_data;
  logic          dcache_req_ready;
  logic          dcache_resp_valid;
  logic [DW-1:0] dcache_resp_block_data;
  logic          mem_req_valid;
  logic          mem_req_cache_type;
  logic          mem_req_type;
  logic [AW-1:0] mem_req_block_addr;
  logic [DW-1:0] mem_req_block_data;
  logic          mem_resp_valid;
  logic          mem_resp_cache_type;
  logic [DW-1:0] mem_resp_block_data;
  logic          err;
`ifdef MEM_SCHED_PERF_CNT_EN
  logic [31:0]   perf_icache_grants;
  logic [31:0]   perf_dcache_grants;
  logic [31:0]   perf_conflict_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mem_req_sched #(
    .BLOCK_ADDR_W(AW),
    .BLOCK_DATA_W(DW),
    .MEM_LATENCY (LAT),
    .TIMEOUT     (TO)
  ) dut (
    .clk                   (clk),
    .rst_aL                (rst_aL),
    .icache_req_valid      (icache_req_valid),
    .icache_req_block_addr (icache_req_block_addr),
    .icache_req_ready      (icache_req_ready),
    .icache_resp_valid     (icache_resp_valid),
    .icache_resp_block_data(icache_resp_block_data),
    .dcache_req_valid      (dcache_req_valid),
    .dcache_req_type       (dcache_req_type),
    .dcache_req_block_addr (dcache_req_block_addr),
    .dcache_req_block_data (dcache_req_block_data),
    .dcache_req_ready      (dcache_req_ready),
    .dcache_resp_valid     (dcache_resp_valid),
    .dcache_resp_block_data(dcache_resp_block_data),
    .mem_req_valid         (mem_req_valid),
    .mem_req_cache_type    (mem_req_cache_type),
    .mem_req_type          (mem_req_type),
    .mem_req_block_addr    (mem_req_block_addr),
    .mem_req_block_data    (mem_req_block_data),
    .mem_resp_valid        (mem_resp_valid),
    .mem_resp_cache_type   (mem_resp_cache_type),
    .mem_resp_block_data   (mem_resp_block_data),
    .err                   (err)
`ifdef MEM_SCHED_PERF_CNT_EN
    ,
    .perf_icache_grants    (perf_icache_grants),
    .perf_dcache_grants    (perf_dcache_grants),
    .perf_conflict_cycles  (perf_conflict_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++)
      v[i*32 +: 32] = {6'(i), a} ^ 32'h5a5a_0000;
    return v;
  endfunction

  // main_mem model: fixed latency, tag echo, optional drop/tag flip.
  typedef struct {
    int            due;
    logic          tag;
    logic [DW-1:0] data;
  } mresp_t;

  mresp_t        mq[$];
  mresp_t        mr;
  int            cyc = 0;
  bit            mem_drop = 0;
  bit            mem_flip = 0;
  logic [DW-1:0] mem_store [logic [AW-1:0]];

  initial begin
    mem_resp_valid      = 1'b0;
    mem_resp_cache_type = 1'b0;
    mem_resp_block_data = '0;
  end

  always @(negedge clk) begin
    cyc++;
    mem_resp_valid = 1'b0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      mem_resp_valid      = 1'b1;
      mem_resp_cache_type = mq[0].tag;
      mem_resp_block_data = mq[0].data;
      mq.delete(0);
    end
    if (mem_req_valid && !mem_drop) begin
      mr.due = cyc + LAT;
      mr.tag = mem_req_cache_type ^ mem_flip;
      if (mem_req_type) begin
        mem_store[mem_req_block_addr] = mem_req_block_data;
        mr.data = {16{32'hdead_beef}};
      end else if (mem_store.exists(mem_req_block_addr)) begin
        mr.data = mem_store[mem_req_block_addr];
      end else begin
        mr.data = pat(mem_req_block_addr);
      end
      mq.push_back(mr);
    end
  end

  task automatic idle_inputs();
    icache_req_valid      = 1'b0;
    icache_req_block_addr = '0;
    dcache_req_valid      = 1'b0;
    dcache_req_type       = 1'b0;
    dcache_req_block_addr = '0;
    dcache_req_block_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_aL = 1'b0;
    repeat (3) @(negedge clk);
    rst_aL = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    idle_inputs();
    rst_aL = 1'b0;
    @(negedge clk);
    obs = {icache_req_ready, dcache_req_ready, icache_resp_valid,
           dcache_resp_valid, mem_req_valid, mem_req_cache_type,
           mem_req_type, err};
    n_cmp++;
    if (obs !== 8'b1100_0000) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 11000000", obs);
    end
    n_cmp++;
    if ((|{icache_resp_block_data, dcache_resp_block_data,
           mem_req_block_data, mem_req_block_addr}) !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data got nonzero want 0");
    end
    rst_aL = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({icache_req_ready, dcache_req_ready, mem_req_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_idle got %b want 110",
               {icache_req_ready, dcache_req_ready, mem_req_valid});
    end
  endtask

  task automatic test_icache_read(input logic [AW-1:0] a);
    logic [3:0] obs, exp;
    @(negedge clk);
    icache_req_valid      = 1'b1;
    icache_req_block_addr = a;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) icache_req_valid = 1'b0;
      obs = {mem_req_valid, icache_resp_valid, dcache_resp_valid,
             icache_req_ready};
      exp = {c == 2, c == 7, 1'b0, c >= 8};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL ird_seq c=%0d got %b want %b", c, obs, exp);
      end
      if (c == 2) begin
        n_cmp++;
        if ({mem_req_cache_type, mem_req_type, mem_req_block_addr}
            !== {2'b00, a}) begin
          n_err++;
          $display("FAIL ird_issue got %b/%b/%h want 0/0/%h",
                   mem_req_cache_type, mem_req_type, mem_req_block_addr, a);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (icache_resp_block_data !== pat(a)) begin
          n_err++;
          $display("FAIL ird_data got %h want %h",
                   icache_resp_block_data, pat(a));
        end
      end
    end
  endtask

  task automatic test_dcache_write();
    logic [3:0]    obs, exp;
    logic [DW-1:0] wd;
    wd = {64{8'ha5}};
    @(negedge clk);
    dcache_req_valid      = 1'b1;
    dcache_req_type       = 1'b1;
    dcache_req_block_addr = 26'h20;
    dcache_req_block_data = wd;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) dcache_req_valid = 1'b0;
      obs = {mem_req_valid, icache_resp_valid, dcache_resp_valid,
             dcache_req_ready};
      exp = {c == 2, 1'b0, c == 7, c >= 8};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL dwr_seq c=%0d got %b want %b", c, obs, exp);
      end
      if (c == 2) begin
        n_cmp++;
        if ({mem_req_cache_type, mem_req_type, mem_req_block_addr,
             mem_req_block_data} !== {2'b11, 26'h20, wd}) begin
          n_err++;
          $display("FAIL dwr_issue got %b/%b/%h data %h",
                   mem_req_cache_type, mem_req_type, mem_req_block_addr,
                   mem_req_block_data);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (dcache_resp_block_data !== '0) begin
          n_err++;
          $display("FAIL dwr_resp_data got %h want 0",
                   dcache_resp_block_data);
        end
      end
    end
  endtask

  task automatic test_tie_alternate();
    int   n;
    logic tags [6];
    int   when [6];
    do_reset();
    icache_req_valid      = 1'b1;
    icache_req_block_addr = 26'h30;
    dcache_req_valid      = 1'b1;
    dcache_req_type       = 1'b0;
    dcache_req_block_addr = 26'h40;
    n = 0;
    for (int c = 1; c <= 80 && n < 6; c++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        tags[n] = mem_req_cache_type;
        when[n] = c;
        n++;
      end
    end
    idle_inputs();
    n_cmp++;
    if (n != 6) begin
      n_err++;
      $display("FAIL tie_budget got %0d issues want 6", n);
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if (tags[k] !== k[0] || when[k] != 2 + 7 * k) begin
          n_err++;
          $display("FAIL tie_order k=%0d got tag %b at %0d want %b at %0d",
                   k, tags[k], when[k], k[0], 2 + 7 * k);
        end
      end
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_tag_mismatch();
    bit dseen;
    do_reset();
    mem_flip = 1;
    dseen = 0;
    icache_req_valid      = 1'b1;
    icache_req_block_addr = 26'h50;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) icache_req_valid = 1'b0;
      if (dcache_resp_valid) dseen = 1;
      n_cmp++;
      if ({icache_resp_valid, err} !== {c == 7, c >= 7}) begin
        n_err++;
        $display("FAIL tag_mm c=%0d got resp/err %b%b want %b%b", c,
                 icache_resp_valid, err, c == 7, c >= 7);
      end
    end
    n_cmp++;
    if (dseen) begin
      n_err++;
      $display("FAIL tag_mm_dresp got pulse want none");
    end
    mem_flip = 0;
  endtask

  task automatic test_timeout();
    bit rseen;
    do_reset();
    mem_drop = 1;
    rseen = 0;
    icache_req_valid      = 1'b1;
    icache_req_block_addr = 26'h60;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) icache_req_valid = 1'b0;
      if (icache_resp_valid || dcache_resp_valid) rseen = 1;
      n_cmp++;
      if ({err, icache_req_ready} !== {c >= 11, c >= 11}) begin
        n_err++;
        $display("FAIL timeout c=%0d got err/rdy %b%b want %b%b", c,
                 err, icache_req_ready, c >= 11, c >= 11);
      end
    end
    n_cmp++;
    if (rseen) begin
      n_err++;
      $display("FAIL timeout_resp got pulse want none");
    end
    mem_drop = 0;
    test_icache_read(26'h64);
  endtask

  task automatic test_reset_mid();
    bit bad;
    do_reset();
    bad = 0;
    icache_req_valid      = 1'b1;
    icache_req_block_addr = 26'h70;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) icache_req_valid = 1'b0;
      if (c == 4) rst_aL = 1'b0;
      if (c == 6) rst_aL = 1'b1;
      if (c >= 6 && ({icache_resp_valid, dcache_resp_valid, err,
                      icache_req_ready, dcache_req_ready} !== 5'b00011))
        bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL reset_mid got resp/err/not-ready want quiet idle");
    end
  endtask

  typedef struct {
    logic          typ;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  task automatic test_random();
    req_t          iq[$], dq[$];
    logic [DW-1:0] ie[$], de[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] ex;
    req_t          r;
    int            busy;
    bit            i_acc, d_acc;
    do_reset();
    busy  = 0;
    i_acc = 0;
    d_acc = 0;
    for (int k = 0; k < 560; k++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        n_cmp++;
        if (busy != 0) begin
          n_err++;
          $display("FAIL rnd_overlap got issue with %0d in flight", busy);
        end
        busy++;
        if (mem_req_cache_type == 1'b0) begin
          n_cmp++;
          if (iq.size() == 0 ||
              {mem_req_type, mem_req_block_addr} !== {1'b0, iq[0].a}) begin
            n_err++;
            $display("FAIL rnd_i_issue got %b/%h want pending read",
                     mem_req_type, mem_req_block_addr);
          end
          if (iq.size() > 0) begin
            ie.push_back(ref_mem.exists(iq[0].a) ? ref_mem[iq[0].a]
                                                 : pat(iq[0].a));
            iq.delete(0);
          end
        end else begin
          n_cmp++;
          if (dq.size() == 0 ||
              {mem_req_type, mem_req_block_addr} !== {dq[0].typ, dq[0].a} ||
              (dq[0].typ && mem_req_block_data !== dq[0].d)) begin
            n_err++;
            $display("FAIL rnd_d_issue got %b/%h want pending request",
                     mem_req_type, mem_req_block_addr);
          end
          if (dq.size() > 0) begin
            if (dq[0].typ) begin
              ref_mem[dq[0].a] = dq[0].d;
              de.push_back('0);
            end else begin
              de.push_back(ref_mem.exists(dq[0].a) ? ref_mem[dq[0].a]
                                                   : pat(dq[0].a));
            end
            dq.delete(0);
          end
        end
      end
      if (icache_resp_valid) begin
        busy--;
        ex = (ie.size() > 0) ? ie[0] : '0;
        n_cmp++;
        if (ie.size() == 0 || icache_resp_block_data !== ex) begin
          n_err++;
          $display("FAIL rnd_i_resp got %h want %h",
                   icache_resp_block_data, ex);
        end
        if (ie.size() > 0) ie.delete(0);
      end
      if (dcache_resp_valid) begin
        busy--;
        ex = (de.size() > 0) ? de[0] : '0;
        n_cmp++;
        if (de.size() == 0 || dcache_resp_block_data !== ex) begin
          n_err++;
          $display("FAIL rnd_d_resp got %h want %h",
                   dcache_resp_block_data, ex);
        end
        if (de.size() > 0) de.delete(0);
      end
      if (i_acc) icache_req_valid = 1'b0;
      if (d_acc) dcache_req_valid = 1'b0;
      if (k < 500 && !icache_req_valid && $urandom_range(0, 2) == 0) begin
        icache_req_valid      = 1'b1;
        icache_req_block_addr = 26'h100 + AW'($urandom_range(0, 15));
      end
      if (k < 500 && !dcache_req_valid && $urandom_range(0, 2) == 0) begin
        dcache_req_valid      = 1'b1;
        dcache_req_type       = 1'($urandom_range(0, 1));
        dcache_req_block_addr = 26'h100 + AW'($urandom_range(0, 15));
        for (int j = 0; j < 16; j++)
          dcache_req_block_data[j*32 +: 32] = $urandom();
      end
      i_acc = icache_req_valid && icache_req_ready;
      d_acc = dcache_req_valid && dcache_req_ready;
      if (i_acc) begin
        r.typ = 1'b0;
        r.a   = icache_req_block_addr;
        r.d   = '0;
        iq.push_back(r);
      end
      if (d_acc) begin
        r.typ = dcache_req_type;
        r.a   = dcache_req_block_addr;
        r.d   = dcache_req_block_data;
        dq.push_back(r);
      end
    end
    n_cmp++;
    if (iq.size() + dq.size() + ie.size() + de.size() != 0 || err !== 1'b0)
    begin
      n_err++;
      $display("FAIL rnd_drain got %0d left err %b want 0 left err 0",
               iq.size() + dq.size() + ie.size() + de.size(), err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_aL = 1'b1;
    test_reset();
    test_icache_read(26'h10);
    test_dcache_write();
    test_tie_alternate();
    test_tag_mismatch();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
